wddl_phase_ctrl: RTL and testbench
==================================

# wddl_phase_ctrl

Precharge/evaluate sequencer that sits directly upstream of a bank of `wddl_dflipflop` cells. It accepts single-rail words over a valid/ready handshake and drives `d_o` and `prechrg_o` through a fixed precharge → evaluate wave. It then samples the returned dual-rail pair (`q_i`/`qbar_i`) and emits the captured word downstream. An optional checker flags any violation of the WDDL rail invariants.

## Interface
- `WIDTH`, 8: data word width, equal to the number of flip-flops in the driven bank.
- `PRE_CYC`, 2: precharge phase length in cycles; legal range 2..15.
- `EVAL_CYC`, 2: evaluate phase length in cycles; legal range 2..15.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  single-rail word.
- `d_o`  out  WIDTH  to flip-flop bank `d_i`.
- `prechrg_o`  out  1  to flip-flop bank `prechrg_i`.
- `q_i`  in  WIDTH  true rail returned from the bank.
- `qbar_i`  in  WIDTH  false rail returned from the bank.
- `out_valid`  out  1  captured word valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  captured word (`q_i` sampled at end of EVAL).
- `err_o`  out  1  rail violation for the word on `out_data`; qualified by `out_valid`.
- `err_cnt_o`  out  8  saturating count of flagged words.

## Operation
- FSM states: IDLE, PRE, EVAL. A 4-bit phase counter runs within each phase.
- IDLE:
  - `prechrg_o`=1, `d_o`=0.
  - `in_ready` = (state==IDLE) & (!out_valid | out_ready) & !rst.
  - On `in_valid & in_ready`: latch `in_data` into hold register, clear pending-error bit, go to PRE.
- PRE:
  - `prechrg_o`=1, `d_o`=0; lasts `PRE_CYC` cycles.
  - On last PRE cycle: sample `q_i | qbar_i`; any nonzero bit sets pending-error. Go to EVAL.
- EVAL:
  - `prechrg_o`=0, `d_o`=hold register; lasts `EVAL_CYC` cycles.
  - On last EVAL cycle:
    - Register `out_data`=`q_i` and set `out_valid`.
    - Error if `(q_i ^ qbar_i) != all-ones` or `q_i != hold`, OR'd with pending-error; registered into `err_o`.
    - Go to IDLE.
- Output slot is single-entry:
  - `out_valid` stays high, with `out_data`/`err_o` stable, until `out_valid & out_ready`.
  - A new accept is allowed in the same cycle as the drain.
- `err_cnt_o`:
  - Increments by 1 when a word is registered with error=1.
  - Saturates at 255; never wraps.
- `d_o` is 0 outside EVAL, so the held word never appears on the rails during precharge.

## Timing
- Reset values:
  - State IDLE, `prechrg_o`=1, `d_o`=0, `out_valid`=0, `out_data`=0, `err_o`=0, `err_cnt_o`=0.
  - `in_ready`=0 while `rst` is high.
- Accept at cycle T:
  - PRE occupies T+1..T+PRE_CYC.
  - EVAL occupies T+PRE_CYC+1..T+PRE_CYC+EVAL_CYC.
  - `out_valid` rises at T+PRE_CYC+EVAL_CYC+1.
- Latency in_accept→out_valid = PRE_CYC+EVAL_CYC+1 cycles; defaults give 5.
- Peak throughput is one word per PRE_CYC+EVAL_CYC+1 cycles when `out_ready` is held high.
- The bank registers `d_o` one edge later, so `q_i` is valid from the 2nd EVAL cycle. This is why the minimum `EVAL_CYC` is 2. The same one-edge delay for precharge gives minimum `PRE_CYC` 2.
- Simultaneous drain and accept in IDLE:
  - `out_valid` falls and the FSM enters PRE in the same cycle.
  - The new word's output appears latency cycles later.
- `out_ready` asserted with no `out_valid` has no effect.
- `rst` asserted mid-PRE or mid-EVAL:
  - Next cycle: IDLE, `prechrg_o`=1, `d_o`=0.
  - In-flight word dropped, `out_valid`=0, `err_cnt_o`=0.

## Configuration
- `WDDL_RAIL_CHECK_EN` defined:
  - PRE-zero and EVAL-complementarity/data checks are compiled in.
  - `err_o` and `err_cnt_o` behave as above.
- Not defined:
  - Checker logic is absent; `err_o`=0 and `err_cnt_o`=0 constant.
  - `qbar_i` is unused; `out_data` is still `q_i` sampled at end of EVAL.
  - FSM and timing are identical.

## Test plan
- Reset then `in_data`=0xA5 accepted at T, ideal bank model, `out_ready`=1:
  - `prechrg_o`=1 at T+1..T+2 and =0 at T+3..T+4.
  - `d_o`=0xA5 only at T+3..T+4.
  - `out_valid`=1, `out_data`=0xA5, `err_o`=0 at T+5.
- Back-to-back words 0x3C then 0xC3, `out_ready`=1:
  - Second accept occurs in the drain cycle of the first.
  - Outputs 0x3C then 0xC3, 5 cycles apart.
- Hold `out_ready`=0 after word 0x11:
  - `out_valid` and 0x11 remain stable; `in_ready`=0 throughout.
  - Raising `out_ready` completes the drain, and the next word is accepted in that same cycle.
- Bank model forces `qbar_i[0]`=1 during PRE on word 0x00:
  - `err_o`=1 with that word; `err_cnt_o`=1.
- Bank model returns `q_i`=`qbar_i`=0xFF in EVAL for 300 words:
  - Every word carries `err_o`=1; `err_cnt_o` saturates at 255.
  - Undefined macro: same stimulus gives `err_o`=0 and `err_cnt_o`=0.
- Assert `rst` on 2nd EVAL cycle of word 0x5A:
  - Next cycle: IDLE, `prechrg_o`=1, `d_o`=0.
  - No `out_valid` for 0x5A; `err_cnt_o`=0.

Source files
------------

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate sequencer driving a bank of WDDL flip-flops and capturing the returned rails.
// Optional rail-invariant checker compiled in when WDDL_RAIL_CHECK_EN is defined.
module wddl_phase_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRE_CYC  = 2,
    parameter int EVAL_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] d_o,
    output logic             prechrg_o,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] qbar_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_o,
    output logic [7:0]       err_cnt_o,
    output logic [1:0]       state_dbg
);

    // Handshakes: a word moves when valid & ready are both high at a rising edge;
    // valid never waits on ready, and the sender holds data stable while valid is high.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    localparam logic [3:0] PRE_LAST  = 4'(PRE_CYC - 1);
    localparam logic [3:0] EVAL_LAST = 4'(EVAL_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       phase_cnt;
    logic [3:0]       phase_cnt_nxt;
    logic             pre_last;
    logic             eval_last;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] hold;

    assign in_ready  = (state == S_IDLE) & (!out_valid | out_ready) & !rst;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
        end
    end

    // The held word reaches d_o only during EVAL; both rails stay precharged otherwise.
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        pre_last      = 1'b0;
        eval_last     = 1'b0;
        prechrg_o     = 1'b1;
        d_o           = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt     = S_PRE;
                    phase_cnt_nxt = 4'd0;
                end
            end
            S_PRE: begin
                if (phase_cnt == PRE_LAST) begin
                    pre_last      = 1'b1;
                    state_nxt     = S_EVAL;
                    phase_cnt_nxt = 4'd0;
                end else begin
                    phase_cnt_nxt = phase_cnt + 4'd1;
                end
            end
            S_EVAL: begin
                prechrg_o = 1'b0;
                d_o       = hold;
                if (phase_cnt == EVAL_LAST) begin
                    eval_last     = 1'b1;
                    state_nxt     = S_IDLE;
                    phase_cnt_nxt = 4'd0;
                end else begin
                    phase_cnt_nxt = phase_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                phase_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Single-entry output slot; capture and drain never coincide because accept needs a free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                hold <= in_data;
            end
            if (eval_last) begin
                out_valid <= 1'b1;
                out_data  <= q_i;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef WDDL_RAIL_CHECK_EN
    logic       pend_err;
    logic       eval_err;
    logic       err_q;
    logic [7:0] err_cnt_q;

    // Evaluated rails must be complementary and carry the word that was driven.
    assign eval_err = pend_err
                    | ((q_i ^ qbar_i) != {WIDTH{1'b1}})
                    | (q_i != hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_err  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (accept) begin
                pend_err <= 1'b0;
            end else if (pre_last && (|(q_i | qbar_i))) begin
                pend_err <= 1'b1;
            end
            if (eval_last) begin
                err_q <= eval_err;
                if (eval_err && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_chk;

    assign unused_chk = ^{qbar_i, pre_last};
    assign err_o      = 1'b0;
    assign err_cnt_o  = 8'd0;
`endif

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// Randomized bench for wddl_phase_ctrl: behavioural bank model with fault modes and a
// cycle-offset reference model of the precharge/evaluate wave and the output slot.
module tb_wddl_phase_ctrl;
  localparam int W    = 8;
  localparam int PRE  = 2;
  localparam int EVAL = 2;
`ifdef WDDL_RAIL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int M_OK   = 0;
  localparam int M_PRE  = 1;
  localparam int M_FF   = 2;
  localparam int M_FLIP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] d_o;
  logic         prechrg_o;
  logic [W-1:0] q_i;
  logic [W-1:0] qbar_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         err_o;
  logic [7:0]   err_cnt_o;
  logic [1:0]   state_dbg;

  wddl_phase_ctrl #(.WIDTH(W), .PRE_CYC(PRE), .EVAL_CYC(EVAL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .d_o(d_o), .prechrg_o(prechrg_o), .q_i(q_i), .qbar_i(qbar_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bank model ----------------
  logic [W-1:0] bank_q  = '0;
  logic [W-1:0] bank_qb = '0;
  logic [W-1:0] flip_mask = 8'h01;
  int           bank_mode = 0;

  always @(posedge clk) begin
    bank_q  <= prechrg_o ? '0 : d_o;
    bank_qb <= prechrg_o ? '0 : ~d_o;
  end

  always_comb begin
    q_i    = bank_q;
    qbar_i = bank_qb;
    if (!prechrg_o && bank_mode == M_FF) begin
      q_i    = '1;
      qbar_i = '1;
    end
    if (!prechrg_o && bank_mode == M_FLIP) q_i = bank_q ^ flip_mask;
    if (prechrg_o && bank_mode == M_PRE) qbar_i[0] = 1'b1;
  end

  // ---------------- scoreboard / reference model ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  logic [7:0]   exp_cnt = 8'd0;
  bit           act = 1'b0;
  int           act_t = 0;
  logic [W-1:0] act_data = '0;
  logic [W-1:0] act_mask = '0;
  int           act_mode = 0;
  bit           accepted = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A word accepted in cycle T spends offsets 1..PRE in precharge, PRE+1..PRE+EVAL in
  // evaluate, and lands in the output slot at the edge closing offset PRE+EVAL.
  task automatic model_cycle();
    int           off;
    bit           in_eval;
    bit           exp_rdy;
    logic [W-1:0] d;
    logic         e;
    off     = act ? (cyc - act_t) : 0;
    in_eval = act && (off > PRE);
    check("prechrg_o", prechrg_o, !in_eval);
    check("d_o", d_o, in_eval ? act_data : '0);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0]);
      check("err_o", err_o, exp_err_q[0]);
    end
    check("err_cnt_o", err_cnt_o, exp_cnt);
    exp_rdy = !act && (exp_q.size() == 0 || out_ready) && !rst;
    check("in_ready", in_ready, exp_rdy);
    accepted = 1'b0;
    if (rst) begin
      act = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
      exp_cnt = 8'd0;
    end else begin
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
      end
      if (act && off == PRE + EVAL) begin
        case (act_mode)
          M_FF:    begin d = '1;                  e = 1'b1; end
          M_FLIP:  begin d = act_data ^ act_mask; e = 1'b1; end
          M_PRE:   begin d = act_data;            e = 1'b1; end
          default: begin d = act_data;            e = 1'b0; end
        endcase
        e = e & CHK;
        exp_q.push_back(d);
        exp_err_q.push_back(e);
        if (e && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        act = 1'b0;
      end
      if (in_valid && exp_rdy) begin
        act       = 1'b1;
        act_t     = cyc;
        act_data  = in_data;
        act_mode  = drv_mode;
        act_mask  = W'($urandom_range(1, 255));
        flip_mask = act_mask;
        bank_mode = drv_mode;
        accepted  = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  logic [W-1:0] stim_q[$];
  int           mode_q[$];
  int           drv_mode = 0;
  int           gap_max = 0;
  int           gap_cnt = 0;
  int           or_mode = 1;
  int           rst_pm = 0;
  bit           force_rst = 1'b1;
  bit           rst_eval2 = 1'b0;

  task automatic drive();
    if (in_valid && accepted) in_valid = 1'b0;
    rst = force_rst || (rst_pm != 0 && $urandom_range(0, 999) < rst_pm);
    if (rst_eval2 && act && (cyc - act_t) == PRE + 2) begin
      rst       = 1'b1;
      rst_eval2 = 1'b0;
    end
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = $urandom_range(0, 1) != 0;
    endcase
    if (!in_valid) begin
      if (gap_cnt > 0) begin
        gap_cnt--;
      end else if (stim_q.size() != 0) begin
        in_valid = 1'b1;
        in_data  = stim_q.pop_front();
        drv_mode = mode_q.pop_front();
        gap_cnt  = $urandom_range(0, gap_max);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic push_word(input logic [W-1:0] data, input int mode);
    stim_q.push_back(data);
    mode_q.push_back(mode);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || in_valid || act || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < budget, 1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    repeat (3) tick();
    force_rst = 1'b0;

    or_mode = 1;
    push_word(8'hA5, M_OK);
    run_until_idle(50);

    push_word(8'h3C, M_OK);
    push_word(8'hC3, M_OK);
    run_until_idle(50);

    or_mode = 0;
    push_word(8'h11, M_OK);
    push_word(8'h22, M_OK);
    repeat (15) tick();
    or_mode = 1;
    run_until_idle(50);

    push_word(8'h00, M_PRE);
    run_until_idle(50);

    for (int i = 0; i < 300; i++) push_word(W'($urandom_range(0, 255)), M_FF);
    run_until_idle(3000);
    check("err_cnt_saturated", err_cnt_o, CHK ? 8'd255 : 8'd0);

    rst_eval2 = 1'b1;
    push_word(8'h5A, M_OK);
    repeat (15) tick();
    check("err_cnt_after_rst", err_cnt_o, 8'd0);

    or_mode = 2;
    gap_max = 3;
    rst_pm  = 5;
    for (int i = 0; i < 200; i++)
      push_word(W'($urandom_range(0, 255)), $urandom_range(0, 3));
    run_until_idle(6000);
    rst_pm  = 0;
    or_mode = 1;
    run_until_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
